active_piece_ctrl: RTL and testbench

Sequential producer of the `active_piece_t` record that `piece_decoder` consumes. It holds the falling piece and spawns new pieces from an internal LFSR. It turns player commands and gravity ticks into candidate moves, checks each candidate with the board checker over a valid/done handshake, and commits the move or locks the piece. It sits in the GAME_clk domain between input handling, the gravity timer and the board/collision logic.

---
 rtl/active_piece_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_active_piece_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/active_piece_ctrl.sv
// Falling-piece controller: spawns from an LFSR and checks each move with an external checker; TETRIS_WALL_KICK_EN adds rotation kicks.
// Latency: at least 3 cycles IDLE-to-IDLE per move; cmd_ready is low outside IDLE and while a gravity step is pending.
package tetris_pkg;
    typedef enum logic [2:0] {PIECE_I, PIECE_O, PIECE_T, PIECE_L, PIECE_J, PIECE_S, PIECE_Z} piece_t;
    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_t;
    typedef struct packed {
        piece_t     piece;
        rot_t       rot;
        logic [3:0] x;
        logic [4:0] y;
    } active_piece_t;
endpackage

module active_piece_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned SPAWN_X   = 3,
    parameter int unsigned SPAWN_Y   = 0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd,
    input  logic          gravity_tick,
    output logic          chk_valid,
    output active_piece_t chk_piece,
    input  logic          chk_done,
    input  logic          chk_collide,
    output active_piece_t active_piece,
    output piece_t        next_piece,
    output logic          lock_valid,
    output logic          game_over
);

    localparam logic [1:0] CMD_LEFT  = 2'd0;
    localparam logic [1:0] CMD_RIGHT = 2'd1;
    localparam logic [1:0] CMD_DOWN  = 2'd2;
    localparam logic [1:0] CMD_ROT   = 2'd3;

    typedef enum logic [2:0] {
        S_SPAWN,
        S_SPAWN_CHK,
        S_IDLE,
        S_MOVE_CHK,
`ifdef TETRIS_WALL_KICK_EN
        S_KICK_CHK,
`endif
        S_LOCK,
        S_OVER
    } state_t;

    function automatic piece_t lfsr_type(input logic [7:0] l);
        lfsr_type = (l[2:0] == 3'd7) ? PIECE_I : piece_t'(l[2:0]);
    endfunction

    function automatic active_piece_t apply_cmd(input active_piece_t p, input logic [1:0] c);
        active_piece_t r;
        r = p;
        case (c)
            CMD_LEFT:  r.x   = p.x - 4'd1;
            CMD_RIGHT: r.x   = p.x + 4'd1;
            CMD_DOWN:  r.y   = p.y + 5'd1;
            default:   r.rot = rot_t'(p.rot + 2'd1);
        endcase
        apply_cmd = r;
    endfunction

    state_t        state_q;
    logic [7:0]    lfsr_q;
    active_piece_t cand_q;
    active_piece_t act_q;
    piece_t        next_q;
    logic          chk_vld_q;
    logic          lock_q;
    logic          over_q;
    logic          grav_pend_q;
    logic [1:0]    mv_q;
`ifdef TETRIS_WALL_KICK_EN
    logic          kick_q;
`endif

    logic          grav_req;
    logic [1:0]    req_cmd_d;
    active_piece_t cand_d;

    // A pending or live gravity step always wins over a player command.
    always_comb begin
        grav_req  = grav_pend_q || gravity_tick;
        req_cmd_d = grav_req ? CMD_DOWN : cmd;
        cand_d    = apply_cmd(act_q, req_cmd_d);
    end

    assign cmd_ready    = (state_q == S_IDLE) && !gravity_tick && !grav_pend_q;
    assign chk_valid    = chk_vld_q;
    assign chk_piece    = cand_q;
    assign active_piece = act_q;
    assign next_piece   = next_q;
    assign lock_valid   = lock_q;
    assign game_over    = over_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SPAWN;
            lfsr_q      <= LFSR_SEED;
            cand_q      <= '0;
            act_q       <= '0;
            next_q      <= lfsr_type(LFSR_SEED);
            chk_vld_q   <= 1'b0;
            lock_q      <= 1'b0;
            over_q      <= 1'b0;
            grav_pend_q <= 1'b0;
            mv_q        <= CMD_LEFT;
`ifdef TETRIS_WALL_KICK_EN
            kick_q      <= 1'b0;
`endif
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            lock_q <= 1'b0;
            if (gravity_tick && state_q != S_IDLE && state_q != S_OVER)
                grav_pend_q <= 1'b1;

            case (state_q)
                S_SPAWN: begin
                    cand_q  <= '{piece: next_q, rot: ROT_0, x: 4'(SPAWN_X), y: 5'(SPAWN_Y)};
                    state_q <= S_SPAWN_CHK;
                end
                S_SPAWN_CHK: begin
                    if (!chk_vld_q) begin
                        chk_vld_q <= 1'b1;
                    end else if (chk_done) begin
                        chk_vld_q <= 1'b0;
                        if (chk_collide) begin
                            over_q  <= 1'b1;
                            state_q <= S_OVER;
                        end else begin
                            act_q   <= cand_q;
                            next_q  <= lfsr_type(lfsr_q);
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (grav_req || (cmd_valid && cmd_ready)) begin
                        grav_pend_q <= 1'b0;
                        cand_q      <= cand_d;
                        mv_q        <= req_cmd_d;
                        state_q     <= S_MOVE_CHK;
                    end
                end
                S_MOVE_CHK: begin
                    if (!chk_vld_q) begin
                        chk_vld_q <= 1'b1;
                    end else if (chk_done) begin
                        chk_vld_q <= 1'b0;
                        if (!chk_collide) begin
                            act_q   <= cand_q;
                            state_q <= S_IDLE;
                        end else if (mv_q == CMD_DOWN) begin
                            lock_q  <= 1'b1;
                            state_q <= S_LOCK;
`ifdef TETRIS_WALL_KICK_EN
                        end else if (mv_q == CMD_ROT) begin
                            cand_q.x <= cand_q.x - 4'd1;
                            kick_q   <= 1'b0;
                            state_q  <= S_KICK_CHK;
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
`ifdef TETRIS_WALL_KICK_EN
                // First retry sits at x-1; stepping +2 lands the second at x+1.
                S_KICK_CHK: begin
                    if (!chk_vld_q) begin
                        chk_vld_q <= 1'b1;
                    end else if (chk_done) begin
                        chk_vld_q <= 1'b0;
                        if (!chk_collide) begin
                            act_q   <= cand_q;
                            state_q <= S_IDLE;
                        end else if (!kick_q) begin
                            cand_q.x <= cand_q.x + 4'd2;
                            kick_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
`endif
                S_LOCK:  state_q <= S_SPAWN;
                S_OVER:  state_q <= S_OVER;
                default: state_q <= S_SPAWN;
            endcase
        end
    end

endmodule

// File: tb/tb_active_piece_ctrl.sv
// Directed bench for active_piece_ctrl with a scripted combinational checker.
module tb_active_piece_ctrl;
    import tetris_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd;
    logic          gravity_tick;
    logic          chk_valid;
    active_piece_t chk_piece;
    logic          chk_done;
    logic          chk_collide;
    active_piece_t active_piece;
    piece_t        next_piece;
    logic          lock_valid;
    logic          game_over;

    int total = 0;
    int bad   = 0;

    bit       done_en  = 1'b1;
    bit [7:0] coll_seq = 8'h00;
    int       hs_cnt   = 0;
    int       hs_base  = 0;
    int       lock_cnt = 0;
    int       idx;
    piece_t   spawn_type;

    always #5 clk = ~clk;

    active_piece_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd          (cmd),
        .gravity_tick (gravity_tick),
        .chk_valid    (chk_valid),
        .chk_piece    (chk_piece),
        .chk_done     (chk_done),
        .chk_collide  (chk_collide),
        .active_piece (active_piece),
        .next_piece   (next_piece),
        .lock_valid   (lock_valid),
        .game_over    (game_over)
    );

    // Checker model: answers in the same cycle, collision taken from a per-handshake script.
    always_comb begin
        idx         = hs_cnt - hs_base;
        chk_done    = chk_valid && done_en;
        chk_collide = (idx >= 0 && idx < 8) ? coll_seq[idx] : 1'b0;
    end

    always @(posedge clk) begin
        if (chk_valid && chk_done) hs_cnt <= hs_cnt + 1;
        if (lock_valid) lock_cnt <= lock_cnt + 1;
    end

    task automatic send_cmd(input logic [1:0] c, output int cyc);
        int w;
        cyc = -1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (cmd_ready) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        active_piece_t exp;
        int got;
        int hs0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd = 2'd0;
        gravity_tick = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (active_piece !== '0 || chk_valid !== 1'b0 || lock_valid !== 1'b0 ||
            game_over !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs act=%h chk_vld=%b lock=%b over=%b rdy=%b exp all zero",
                     active_piece, chk_valid, lock_valid, game_over, cmd_ready);
        end
        total++;
        if (next_piece !== PIECE_S) begin
            bad++;
            $display("FAIL reset_next_piece got=%0d exp=%0d", next_piece, PIECE_S);
        end
        exp = '{piece: PIECE_S, rot: ROT_0, x: 4'd3, y: 5'd0};
        hs0 = hs_cnt;
        rst_n = 1'b1;
        got = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (chk_valid) begin
                total++;
                if (chk_piece !== exp) begin
                    bad++;
                    $display("FAIL spawn_candidate got=%h exp=%h", chk_piece, exp);
                end
            end
            if (cmd_ready) begin
                got = i;
                break;
            end
        end
        total++;
        if (got < 1) begin
            bad++;
            $display("FAIL reset_to_ready got=%0d exp=<=4 cycles", got);
        end
        total++;
        if (active_piece !== exp) begin
            bad++;
            $display("FAIL spawn_commit got=%h exp=%h", active_piece, exp);
        end
        total++;
        if (hs_cnt - hs0 != 1) begin
            bad++;
            $display("FAIL spawn_handshakes got=%0d exp=1", hs_cnt - hs0);
        end
        total++;
        if (next_piece !== PIECE_S) begin
            bad++;
            $display("FAIL next_after_spawn got=%0d exp=%0d", next_piece, PIECE_S);
        end
    endtask

    task automatic test_left_rot;
        active_piece_t exp;
        int cyc;
        coll_seq = 8'h00;
        hs_base = hs_cnt;
        send_cmd(2'd0, cyc);
        exp = '{piece: PIECE_S, rot: ROT_0, x: 4'd2, y: 5'd0};
        total++;
        if (active_piece !== exp) begin
            bad++;
            $display("FAIL left_commit got=%h exp=%h", active_piece, exp);
        end
        total++;
        if (cyc != 3) begin
            bad++;
            $display("FAIL idle_to_idle got=%0d exp=3", cyc);
        end
        for (int k = 1; k <= 4; k++) begin
            send_cmd(2'd3, cyc);
            exp.rot = rot_t'(k[1:0]);
            total++;
            if (active_piece !== exp) begin
                bad++;
                $display("FAIL rot_step%0d got=%h exp=%h", k, active_piece, exp);
            end
        end
    endtask

    task automatic test_down_lock;
        active_piece_t exp;
        int cyc;
        int lock0;
        coll_seq = 8'h01;
        hs_base = hs_cnt;
        spawn_type = next_piece;
        lock0 = lock_cnt;
        send_cmd(2'd2, cyc);
        total++;
        if (cyc < 1) begin
            bad++;
            $display("FAIL lock_respawn_timeout got=%0d exp=ready", cyc);
        end
        total++;
        if (lock_cnt - lock0 != 1) begin
            bad++;
            $display("FAIL lock_pulses got=%0d exp=1", lock_cnt - lock0);
        end
        exp = '{piece: spawn_type, rot: ROT_0, x: 4'd3, y: 5'd0};
        total++;
        if (active_piece !== exp) begin
            bad++;
            $display("FAIL respawn got=%h exp=%h", active_piece, exp);
        end
    endtask

    task automatic test_gravity;
        active_piece_t exp;
        int hs0;
        coll_seq = 8'h00;
        hs_base = hs_cnt;
        done_en = 1'b0;
        cmd_valid = 1'b1;
        cmd = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gravity_tick = 1'b1;
            @(negedge clk);
            gravity_tick = 1'b0;
            @(negedge clk);
        end
        hs0 = hs_cnt;
        done_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (active_piece.x == 4'd2) break;
            @(negedge clk);
        end
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL grav_pend_blocks_ready got=%b exp=0", cmd_ready);
        end
        repeat (10) @(negedge clk);
        total++;
        if (hs_cnt - hs0 != 2) begin
            bad++;
            $display("FAIL grav_merge_handshakes got=%0d exp=2", hs_cnt - hs0);
        end
        exp = '{piece: spawn_type, rot: ROT_0, x: 4'd2, y: 5'd1};
        total++;
        if (active_piece !== exp) begin
            bad++;
            $display("FAIL grav_down got=%h exp=%h", active_piece, exp);
        end
    endtask

    task automatic test_kick;
        active_piece_t exp;
        int cyc;
        int hs0;
        coll_seq = 8'h03;
        hs_base = hs_cnt;
        hs0 = hs_cnt;
        send_cmd(2'd3, cyc);
        repeat (3) @(negedge clk);
`ifdef TETRIS_WALL_KICK_EN
        exp = '{piece: spawn_type, rot: ROT_90, x: 4'd3, y: 5'd1};
        total++;
        if (hs_cnt - hs0 != 3) begin
            bad++;
            $display("FAIL kick_handshakes got=%0d exp=3", hs_cnt - hs0);
        end
`else
        exp = '{piece: spawn_type, rot: ROT_0, x: 4'd2, y: 5'd1};
        total++;
        if (hs_cnt - hs0 != 1) begin
            bad++;
            $display("FAIL rot_collide_handshakes got=%0d exp=1", hs_cnt - hs0);
        end
`endif
        total++;
        if (active_piece !== exp) begin
            bad++;
            $display("FAIL rot_collide_result got=%h exp=%h", active_piece, exp);
        end
    endtask

    task automatic test_game_over;
        int viol;
        coll_seq = 8'hFF;
        hs_base = hs_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (game_over) break;
            @(negedge clk);
        end
        total++;
        if (game_over !== 1'b1 || active_piece !== '0) begin
            bad++;
            $display("FAIL spawn_collide over=%b act=%h exp over=1 act=0", game_over, active_piece);
        end
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            gravity_tick = 1'b1;
            @(negedge clk);
            gravity_tick = 1'b0;
            @(negedge clk);
            if (cmd_ready !== 1'b0 || chk_valid !== 1'b0 || game_over !== 1'b1) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL over_sticky violations=%0d exp=0", viol);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (game_over !== 1'b0) begin
            bad++;
            $display("FAIL async_clear_over got=%b exp=0", game_over);
        end
        coll_seq = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midcheck;
        active_piece_t exp;
        int cyc;
        int lock0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        hs_base = hs_cnt;
        done_en = 1'b0;
        cmd_valid = 1'b1;
        cmd = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (chk_valid !== 1'b1) begin
            bad++;
            $display("FAIL chk_held got=%b exp=1", chk_valid);
        end
        lock0 = lock_cnt;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (chk_valid !== 1'b0 || active_piece !== '0 || lock_valid !== 1'b0) begin
            bad++;
            $display("FAIL midcheck_reset chk_vld=%b act=%h lock=%b exp 0/0/0",
                     chk_valid, active_piece, lock_valid);
        end
        done_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd(2'd1, cyc);
        exp = '{piece: PIECE_S, rot: ROT_0, x: 4'd4, y: 5'd0};
        total++;
        if (active_piece !== exp || lock_cnt != lock0) begin
            bad++;
            $display("FAIL after_abort act=%h locks=%0d exp act=%h locks=%0d",
                     active_piece, lock_cnt - lock0, exp, 0);
        end
    endtask

    initial begin
        test_reset();
        test_left_rot();
        test_down_lock();
        test_gravity();
        test_kick();
        test_game_over();
        test_reset_midcheck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
